ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
// - Execute stage; consumes the ID/EX latch outputs, produces the EX/MEM latch contents.
// - Operand forwarding from MEM/WB, ALU evaluation, branch/JR resolution with front-end redirect.
// - Owns the EX/MEM pipeline register, including stall, flush and sticky-halt handling.
// PARAMETERS
// - RA_REG   31  link register index written by jumpAL
// - CNT_W    16  width of the branch statistics counters (STATS_EN only)
// PORTS
// - CLK            in   1   clock, rising edge
// - RST            in   1   synchronous, active-high reset
// - ex_mem_en      in   1   EX/MEM load enable; 0 = hold (downstream stall)
// - ex_mem_flush   in   1   clear EX/MEM to bubble at next edge
// - instr_i, next_pc_i, rdat1_i, rdat2_i, simm_i  in  32 each  ID/EX word outputs
// - alusrc_i, memwr_i, memrd_i, regwr_i, lui_i, halt_i, memtoreg_i, regdst_i, jal_i, jr_i, taken_i  in  1 each  ID/EX controls
// - aluop_i        in   4   aluop_t
// - rs_i, rt_i, rd_i  in  5 each  register indices
// - mem_regwr, wb_regwr  in  1   forwarding source write enables
// - mem_wsel, wb_wsel    in  5   forwarding destination indices
// - mem_fwd, wb_fwd      in  32  forwarding data
// - alu_out, store_out   out 32  registered ALU result / store data
// - npc_out              out 32  registered next_PC
// - wsel_out             out 5   registered destination
// - regwr_out, memwr_out, memrd_out, memtoreg_out, halt_out  out 1  registered controls
// - redirect             out 1   combinational: front end must load redirect_pc and flush IF/ID, ID/EX
// - redirect_pc          out 32  combinational redirect target
// BEHAVIOUR
// - Reset: every registered output 0; statistics counters 0; sticky halt cleared.
// - Forwarding (per operand A=rs, B=rt): MEM match beats WB match beats rdat; match = regwr & wsel==idx & idx!=0.
// - Operand B into ALU = alusrc_i ? simm_i : fwdB; store_out takes fwdB.
// - ALU: SLL/SRL shift fwdB by A[4:0]; ADD/SUB wrap mod 2^32, no overflow trap; AND/OR/XOR/NOR bitwise;
//   SLT signed, SLTU unsigned (result 0 or 1).
// - lui_i: result = {simm_i[15:0],16'h0}. jal_i: result = next_pc_i, wsel = RA_REG.
// - wsel otherwise: regdst_i ? rd_i : rt_i.
// - Branch: opcode instr_i[31:26] 6'h04 BEQ taken iff A==B; 6'h05 BNE taken iff A!=B.
// - Branch target = next_pc_i + (simm_i<<2). Mispredict iff actual != taken_i.
// - Mispredict: redirect=1; redirect_pc = actual ? target : next_pc_i.
// - jr_i: redirect=1, redirect_pc = forwarded A, regardless of taken_i.
// - redirect only while ex_mem_en=1 and sticky halt=0 (held instr re-asserts nothing until it advances).
// - EX/MEM update, priority: RST > ex_mem_flush > !ex_mem_en (hold) > load.
//   - Flush loads a bubble: all controls 0, data 0.
//   - Flush and en both high: flush wins.
// - Sticky halt: once halt_out=1 it stays 1 until RST; later loads are forced to bubble, redirect forced 0.
// - Latency: one cycle, ID/EX outputs -> EX/MEM outputs.
// - Reset mid-stall/mid-redirect: next edge shows reset values, no residual redirect.
// CONFIGURATION
// - STATS_EN defined: adds outputs br_count, br_miss (CNT_W each).
//   - br_count +1 per BEQ/BNE loaded into EX/MEM; br_miss +1 per mispredict loaded.
//   - Counters saturate at all-ones; cleared by RST only.
// - STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - ADD rs=1(5) rt=2(7), no hazards, en=1 -> next edge alu_out=12, wsel_out=rd, regwr_out=1.
// - Forwarding: rs=3, mem_wsel=3 mem_fwd=0xAA, wb_wsel=3 wb_fwd=0xBB -> MEM value 0xAA used;
//   rs=0 with mem_wsel=0 -> rdat1 used.
// - BEQ A=B=4, taken_i=0, next_pc=0x100, simm=3 -> redirect=1, redirect_pc=0x10C;
//   taken_i=1 -> redirect=0.
// - JR rs=31 fwd 0x400 -> redirect_pc=0x400. JAL next_pc=0x24 -> alu_out=0x24, wsel_out=31.
// - en=0 for 3 cycles -> outputs held, redirect=0; flush=1,en=1 together -> bubble loaded.
// - halt_i loaded -> halt_out=1; next ADD loaded as bubble.
//   STATS_EN: 3 branches with 1 mispredict -> br_count=3, br_miss=1.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/JR resolution with front-end
// redirect, and the EX/MEM pipeline register with stall, flush and sticky halt.
// Optional branch statistics counters are built when STATS_EN is defined.
module ex_stage #(
  parameter int RA_REG = 31,
  parameter int CNT_W  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_mem_en,
  input  logic        ex_mem_flush,
  input  logic [31:0] instr_i,
  input  logic [31:0] next_pc_i,
  input  logic [31:0] rdat1_i,
  input  logic [31:0] rdat2_i,
  input  logic [31:0] simm_i,
  input  logic        alusrc_i,
  input  logic        memwr_i,
  input  logic        memrd_i,
  input  logic        regwr_i,
  input  logic        lui_i,
  input  logic        halt_i,
  input  logic        memtoreg_i,
  input  logic        regdst_i,
  input  logic        jal_i,
  input  logic        jr_i,
  input  logic        taken_i,
  input  logic [3:0]  aluop_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic        mem_regwr,
  input  logic        wb_regwr,
  input  logic [4:0]  mem_wsel,
  input  logic [4:0]  wb_wsel,
  input  logic [31:0] mem_fwd,
  input  logic [31:0] wb_fwd,
  output logic [31:0] alu_out,
  output logic [31:0] store_out,
  output logic [31:0] npc_out,
  output logic [4:0]  wsel_out,
  output logic        regwr_out,
  output logic        memwr_out,
  output logic        memrd_out,
  output logic        memtoreg_out,
  output logic        halt_out,
  output logic        redirect,
  output logic [31:0] redirect_pc
`ifdef STATS_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_miss
`endif
);

  // aluop_t encoding
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLTU = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [4:0] RA_IDX = 5'(RA_REG);

  logic [31:0] fwd_a_s, fwd_b_s, alu_b_s, alu_s, result_s, target_s;
  logic [4:0]  wsel_s;
  logic        is_branch_s, actual_s, mispredict_s, halt_r, load_s;
  logic        unused_instr_s;

  // Only the opcode field of the instruction word is decoded here.
  assign unused_instr_s = ^instr_i[25:0];

  // Operand forwarding: MEM beats WB beats register file; r0 never forwards.
  always_comb begin
    fwd_a_s = rdat1_i;
    fwd_b_s = rdat2_i;
    if (mem_regwr && (mem_wsel == rs_i) && (rs_i != 5'd0)) begin
      fwd_a_s = mem_fwd;
    end else if (wb_regwr && (wb_wsel == rs_i) && (rs_i != 5'd0)) begin
      fwd_a_s = wb_fwd;
    end else begin
      fwd_a_s = rdat1_i;
    end
    if (mem_regwr && (mem_wsel == rt_i) && (rt_i != 5'd0)) begin
      fwd_b_s = mem_fwd;
    end else if (wb_regwr && (wb_wsel == rt_i) && (rt_i != 5'd0)) begin
      fwd_b_s = wb_fwd;
    end else begin
      fwd_b_s = rdat2_i;
    end
  end

  assign alu_b_s = alusrc_i ? simm_i : fwd_b_s;

  // ALU evaluation; shifts move the forwarded B operand by A[4:0].
  always_comb begin
    alu_s = 32'h0;
    case (aluop_i)
      ALU_ADD:  alu_s = fwd_a_s + alu_b_s;
      ALU_SUB:  alu_s = fwd_a_s - alu_b_s;
      ALU_AND:  alu_s = fwd_a_s & alu_b_s;
      ALU_OR:   alu_s = fwd_a_s | alu_b_s;
      ALU_XOR:  alu_s = fwd_a_s ^ alu_b_s;
      ALU_NOR:  alu_s = ~(fwd_a_s | alu_b_s);
      ALU_SLT:  alu_s = ($signed(fwd_a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_s = (fwd_a_s < alu_b_s) ? 32'd1 : 32'd0;
      ALU_SLL:  alu_s = fwd_b_s << fwd_a_s[4:0];
      ALU_SRL:  alu_s = fwd_b_s >> fwd_a_s[4:0];
      default:  alu_s = 32'h0;
    endcase
  end

  // Result and destination selection: JAL links, LUI overrides the ALU.
  always_comb begin
    result_s = alu_s;
    wsel_s   = rt_i;
    if (jal_i) begin
      result_s = next_pc_i;
      wsel_s   = RA_IDX;
    end else if (lui_i) begin
      result_s = {simm_i[15:0], 16'h0000};
      wsel_s   = regdst_i ? rd_i : rt_i;
    end else begin
      result_s = alu_s;
      wsel_s   = regdst_i ? rd_i : rt_i;
    end
  end

  assign is_branch_s  = (instr_i[31:26] == OP_BEQ) || (instr_i[31:26] == OP_BNE);
  assign actual_s     = (instr_i[31:26] == OP_BEQ) ? (fwd_a_s == fwd_b_s)
                      : (instr_i[31:26] == OP_BNE) ? (fwd_a_s != fwd_b_s) : 1'b0;
  assign mispredict_s = is_branch_s && (actual_s != taken_i);
  assign target_s     = next_pc_i + {simm_i[29:0], 2'b00};
  assign load_s       = ex_mem_en && !ex_mem_flush && !halt_r;

  // Redirect only for an instruction that is actually advancing, never once halted.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = next_pc_i;
    if (ex_mem_en && !halt_r) begin
      if (jr_i) begin
        redirect    = 1'b1;
        redirect_pc = fwd_a_s;
      end else if (mispredict_s) begin
        redirect    = 1'b1;
        redirect_pc = actual_s ? target_s : next_pc_i;
      end else begin
        redirect    = 1'b0;
        redirect_pc = next_pc_i;
      end
    end else begin
      redirect    = 1'b0;
      redirect_pc = next_pc_i;
    end
  end

  // EX/MEM register: reset > flush > hold > load (bubble once halted).
  always_ff @(posedge CLK) begin
    if (RST || ex_mem_flush || (ex_mem_en && halt_r)) begin
      alu_out      <= 32'h0;
      store_out    <= 32'h0;
      npc_out      <= 32'h0;
      wsel_out     <= 5'd0;
      regwr_out    <= 1'b0;
      memwr_out    <= 1'b0;
      memrd_out    <= 1'b0;
      memtoreg_out <= 1'b0;
    end else if (!ex_mem_en) begin
      alu_out      <= alu_out;
      store_out    <= store_out;
      npc_out      <= npc_out;
      wsel_out     <= wsel_out;
      regwr_out    <= regwr_out;
      memwr_out    <= memwr_out;
      memrd_out    <= memrd_out;
      memtoreg_out <= memtoreg_out;
    end else begin
      alu_out      <= result_s;
      store_out    <= fwd_b_s;
      npc_out      <= next_pc_i;
      wsel_out     <= wsel_s;
      regwr_out    <= regwr_i;
      memwr_out    <= memwr_i;
      memrd_out    <= memrd_i;
      memtoreg_out <= memtoreg_i;
    end
  end

  // Sticky halt: set by a loaded halt instruction, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_r <= 1'b0;
    end else if (load_s) begin
      halt_r <= halt_i;
    end else begin
      halt_r <= halt_r;
    end
  end

  assign halt_out = halt_r;

`ifdef STATS_EN
  logic [CNT_W-1:0] br_count_r, br_miss_r;

  // Saturating branch / mispredict counters, bumped when the branch is loaded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_count_r <= {CNT_W{1'b0}};
      br_miss_r  <= {CNT_W{1'b0}};
    end else begin
      if (load_s && is_branch_s && (br_count_r != {CNT_W{1'b1}})) begin
        br_count_r <= br_count_r + CNT_W'(1);
      end else begin
        br_count_r <= br_count_r;
      end
      if (load_s && mispredict_s && (br_miss_r != {CNT_W{1'b1}})) begin
        br_miss_r <= br_miss_r + CNT_W'(1);
      end else begin
        br_miss_r <= br_miss_r;
      end
    end
  end

  assign br_count = br_count_r;
  assign br_miss  = br_miss_r;
`endif

endmodule
